// File: rtl/jtkcpu_stk_pkg.sv
// Shared definitions for the JTKCPU push/pull sequencer:
// state encoding, register indices, default width mask, byte-order helper.
package jtkcpu_stk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_BUS,
    ST_FIN
  } stk_st_t;

  localparam int CC = 0;
  localparam int A  = 1;
  localparam int B  = 2;
  localparam int DP = 3;
  localparam int X  = 4;
  localparam int Y  = 5;
  localparam int US = 6;
  localparam int PC = 7;

  localparam logic [7:0] WIDE_DEF = 8'hF0;

  // Which half of a register the current byte is.
  // two = this is the first of two bytes.
  // Pull: high then low. Push: low then high.
  function automatic logic byte_hi(
    input logic pull,
    input logic wide,
    input logic two
  );
    return pull ? two : (wide & ~two);
  endfunction

endpackage

// File: rtl/jtkcpu_stkseq_if.sv
// Byte bus between the stack sequencer (master) and memory (slave).
// req/we/addr/dout from master; din/ack from slave.
interface jtkcpu_stkseq_if #(
  parameter int AW = 16
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic [7:0]    bus_din;
  logic          bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/jtkcpu_prienc.sv
// Priority encoder: i_vec -> o_idx of highest (i_msb=1) or
// lowest (i_msb=0) set bit; o_vld = any bit set.
module jtkcpu_prienc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  input  logic          i_msb,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  // Later assignments win, so the scan order
  // decides which end has priority.
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (i_msb && i_vec[k])
        o_idx = IW'(k);
      if (!i_msb && i_vec[N-1-k])
        o_idx = IW'(N-1-k);
    end
    o_vld = |i_vec;
  end

endmodule

// File: rtl/jtkcpu_stkseq.sv
// Push/pull sequencer: walks the selected registers as byte bus cycles.
// Ports: clk/rst/cen, start/pull/sel/sp_in/reg_rd, bus (master), up_*, sp_*.
module jtkcpu_stkseq
  import jtkcpu_stk_pkg::*;
#(
  parameter int              NREG = 8,
  parameter logic [NREG-1:0] WIDE = NREG'(WIDE_DEF),
  parameter int              AW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               start,
  input  logic               pull,
  input  logic [NREG-1:0]    sel,
  input  logic [AW-1:0]      sp_in,
  input  logic [16*NREG-1:0] reg_rd,
  output logic               busy,
  output logic               done,
  jtkcpu_stkseq_if.master    bus,
  output logic [NREG-1:0]    up_en,
  output logic               up_hilon,
  output logic [7:0]         up_data,
  output logic               sp_up,
  output logic [AW-1:0]      sp_out
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  stk_st_t         r_st;
  logic            r_pull;
  logic [NREG-1:0] r_msk;
  logic [AW-1:0]   r_sp;
  logic [IW-1:0]   r_idx;
  logic            r_two;
  logic            r_busy;
  logic            r_done;
  logic            r_req;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_dout;
  logic            r_spup;
  logic [AW-1:0]   r_spo;

  logic [IW-1:0]   w_idx;
  logic            w_vld;
  logic            w_fire;
  logic [AW-1:0]   w_sp_nx;
  logic [7:0]      w_lo;
  logic [7:0]      w_hi;

  jtkcpu_prienc #(
    .N  (NREG),
    .IW (IW)
  ) u_pe (
    .i_vec (r_msk),
    .i_msb (~r_pull),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  assign w_lo    = reg_rd[{w_idx, 4'd0} +: 8];
  assign w_hi    = reg_rd[{r_idx, 4'd8} +: 8];
  assign w_sp_nx = r_pull ? r_sp + AW'(1) : r_sp - AW'(1);

  // Update strobes coincide with the accepted ack.
  assign w_fire   = cen & r_req & bus.bus_ack;
  assign up_en    = (w_fire & r_pull) ? NREG'(1) << r_idx : '0;
  assign up_hilon = w_fire & r_pull & byte_hi(1'b1, WIDE[r_idx], r_two);
  assign up_data  = (w_fire & r_pull) ? bus.bus_din : 8'd0;

  assign busy         = r_busy;
  assign done         = r_done;
  assign sp_up        = r_spup;
  assign sp_out       = r_spo;
  assign bus.bus_req  = r_req;
  assign bus.bus_we   = r_we;
  assign bus.bus_addr = r_addr;
  assign bus.bus_dout = r_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_pull <= 1'b0;
      r_msk  <= '0;
      r_sp   <= '0;
      r_idx  <= '0;
      r_two  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_req  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_dout <= '0;
      r_spup <= 1'b0;
      r_spo  <= '0;
    end else if (cen) begin
      unique case (r_st)
        ST_IDLE: begin
          if (start) begin
            r_pull <= pull;
            r_msk  <= sel;
            r_sp   <= sp_in;
            r_busy <= 1'b1;
            r_st   <= ST_PICK;
          end
        end
        ST_PICK: begin
          if (w_vld) begin
            r_idx  <= w_idx;
            r_two  <= WIDE[w_idx];
            r_req  <= 1'b1;
            r_we   <= ~r_pull;
            r_addr <= r_pull ? r_sp : r_sp - AW'(1);
            r_dout <= w_lo;
            r_st   <= ST_BUS;
          end else begin
            r_done <= 1'b1;
            r_spup <= 1'b1;
            r_spo  <= r_sp;
            r_st   <= ST_FIN;
          end
        end
        ST_BUS: begin
          if (bus.bus_ack) begin
            r_sp <= w_sp_nx;
            if (r_two) begin
              // second byte of a 16-bit register
              r_two  <= 1'b0;
              r_addr <= r_pull ? w_sp_nx : w_sp_nx - AW'(1);
              r_dout <= w_hi;
            end else begin
              r_req        <= 1'b0;
              r_msk[r_idx] <= 1'b0;
              r_st         <= ST_PICK;
            end
          end
        end
        ST_FIN: begin
          r_done <= 1'b0;
          r_spup <= 1'b0;
          r_busy <= 1'b0;
          r_st   <= ST_IDLE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Self-checking bench for jtkcpu_stkseq: vector table, hand sequences,
// and random operations against a list-based push/pull memory model.
module tb_jtkcpu_stkseq;

  localparam logic [7:0] WM = 8'hF0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } bop_t;

  typedef struct {
    logic [7:0] en;
    logic       hi;
    logic [7:0] data;
  } up_t;

  typedef struct {
    bit          p;
    logic [7:0]  s;
    logic [15:0] sp;
    int          w;
    bit          noisy;
    int          cyc;
    logic [15:0] spo;
  } vec_t;

  logic         clk = 0;
  logic         rst;
  logic         cen;
  logic         start;
  logic         pull;
  logic [7:0]   sel;
  logic [15:0]  sp_in;
  logic [127:0] reg_rd;
  logic         busy;
  logic         done;
  logic [7:0]   up_en;
  logic         up_hilon;
  logic [7:0]   up_data;
  logic         sp_up;
  logic [15:0]  sp_out;

  jtkcpu_stkseq_if #(.AW(16)) bus ();

  jtkcpu_stkseq #(.NREG(8), .WIDE(8'hF0), .AW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .start    (start),
    .pull     (pull),
    .sel      (sel),
    .sp_in    (sp_in),
    .reg_rd   (reg_rd),
    .busy     (busy),
    .done     (done),
    .bus      (bus),
    .up_en    (up_en),
    .up_hilon (up_hilon),
    .up_data  (up_data),
    .sp_up    (sp_up),
    .sp_out   (sp_out)
  );

  always #5 clk = ~clk;

  int          ntest = 0;
  int          nfail = 0;
  logic [7:0]  mem [0:65535];
  logic [15:0] regs [8];
  bop_t        blog[$];
  up_t         ulog[$];
  bop_t        exp_b[$];
  up_t         exp_u[$];
  int          waits = 0;
  bit          force_ack = 0;
  bit          chk_stab = 0;

  always_comb
    for (int i = 0; i < 8; i++) reg_rd[16*i +: 16] = regs[i];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory slave with programmable wait states; logs every accepted byte.
  int          wcnt = 0;
  logic        prev_req = 0, prev_ack = 0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_dout;

  always @(negedge clk) begin
    if (chk_stab && bus.bus_req && prev_req && !prev_ack) begin
      check("stable_addr", 32'(bus.bus_addr), 32'(prev_addr));
      check("stable_dout", 32'(bus.bus_dout), 32'(prev_dout));
    end
    prev_req  = bus.bus_req;
    prev_addr = bus.bus_addr;
    prev_dout = bus.bus_dout;
    if (force_ack) begin
      bus.bus_ack = 1;
      bus.bus_din = 8'hEE;
    end else if (bus.bus_req && !rst) begin
      if (wcnt >= waits) begin
        bus.bus_ack = 1;
        wcnt = 0;
        if (bus.bus_we) begin
          mem[bus.bus_addr] = bus.bus_dout;
          blog.push_back('{bus.bus_addr, 1'b1, bus.bus_dout});
        end else begin
          bus.bus_din = mem[bus.bus_addr];
          blog.push_back('{bus.bus_addr, 1'b0, mem[bus.bus_addr]});
        end
      end else begin
        bus.bus_ack = 0;
        wcnt++;
      end
    end else begin
      bus.bus_ack = 0;
      wcnt = 0;
    end
    prev_ack = bus.bus_ack;
    #1;
    if (|up_en) ulog.push_back('{up_en, up_hilon, up_data});
  end

  // Reference: push pre-decrements writing low then high;
  // pull post-increments reading high then low.
  task automatic model(input bit p, input logic [7:0] s,
                       input logic [15:0] sp0, input int w,
                       output logic [15:0] spf, output int cyc);
    logic [15:0] sp;
    int nb;
    sp = sp0;
    cyc = 2;
    exp_b.delete();
    exp_u.delete();
    if (!p) begin
      for (int i = 7; i >= 0; i--) begin
        if (s[i]) begin
          nb = WM[i] ? 2 : 1;
          cyc += 1 + nb * (1 + w);
          sp = sp - 16'd1;
          exp_b.push_back('{sp, 1'b1, regs[i][7:0]});
          if (WM[i]) begin
            sp = sp - 16'd1;
            exp_b.push_back('{sp, 1'b1, regs[i][15:8]});
          end
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) begin
          nb = WM[i] ? 2 : 1;
          cyc += 1 + nb * (1 + w);
          if (WM[i]) begin
            exp_b.push_back('{sp, 1'b0, mem[sp]});
            exp_u.push_back('{8'b1 << i, 1'b1, mem[sp]});
            sp = sp + 16'd1;
          end
          exp_b.push_back('{sp, 1'b0, mem[sp]});
          exp_u.push_back('{8'b1 << i, 1'b0, mem[sp]});
          sp = sp + 16'd1;
        end
      end
    end
    spf = sp;
  endtask

  task automatic cmp_logs(input string tag);
    check({tag, "_nbus"}, 32'(blog.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < blog.size(); i++)
      check({tag, "_bus"}, {7'd0, blog[i].addr, blog[i].we, blog[i].data},
            {7'd0, exp_b[i].addr, exp_b[i].we, exp_b[i].data});
    check({tag, "_nup"}, 32'(ulog.size()), 32'(exp_u.size()));
    for (int i = 0; i < exp_u.size() && i < ulog.size(); i++)
      check({tag, "_up"}, {15'd0, ulog[i].en, ulog[i].hi, ulog[i].data},
            {15'd0, exp_u[i].en, exp_u[i].hi, exp_u[i].data});
  endtask

  task automatic run_op(input bit p, input logic [7:0] s,
                        input logic [15:0] sp0, input int w,
                        input bit noisy, output int cyc,
                        output logic [15:0] spo);
    bit bad_busy;
    bit got;
    waits = w;
    chk_stab = (w > 0);
    blog.delete();
    ulog.delete();
    bad_busy = 0;
    got = 0;
    @(negedge clk);
    pull = p; sel = s; sp_in = sp0; start = 1;
    @(posedge clk);
    cyc = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = noisy && (cyc == 2 || cyc == 3);
      if (!busy) bad_busy = 1;
      if (done) begin got = 1; break; end
      cyc++;
    end
    start = 0;
    check("timeout", 32'(got), 32'd1);
    if (!got) cyc = -1;
    check("busy_held", 32'(bad_busy), 32'd0);
    check("sp_up_at_done", 32'(sp_up), 32'(got));
    spo = sp_out;
    @(negedge clk);
    check("done_1cyc", {30'd0, done, sp_up}, 32'd0);
    check("busy_off", 32'(busy), 32'd0);
    chk_stab = 0;
  endtask

  task automatic uchk(input int k, input logic [7:0] en, input logic hi,
                      input logic [7:0] d);
    if (k < ulog.size())
      check("hand_up", {15'd0, ulog[k].en, ulog[k].hi, ulog[k].data},
            {15'd0, en, hi, d});
    else
      check("hand_up_missing", 32'(ulog.size()), 32'(k + 1));
  endtask

  vec_t        tbl[7];
  int          cyc, mcyc;
  logic [15:0] spo, mspo;
  bit          got;

  initial begin
    tbl[0] = '{0, 8'h81, 16'h1000, 0, 0, 7,  16'h0FFD};
    tbl[1] = '{1, 8'h81, 16'h0FFD, 0, 0, 7,  16'h1000};
    tbl[2] = '{0, 8'h00, 16'h1234, 0, 0, 2,  16'h1234};
    tbl[3] = '{0, 8'h10, 16'h0001, 3, 0, 11, 16'hFFFF};
    tbl[4] = '{1, 8'h10, 16'hFFFF, 0, 0, 5,  16'h0001};
    tbl[5] = '{1, 8'h00, 16'hABCD, 0, 0, 2,  16'hABCD};
    tbl[6] = '{0, 8'h06, 16'h2000, 1, 1, 8,  16'h1FFE};

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    regs[0] = 16'hAA56;
    regs[1] = 16'h0011;
    regs[2] = 16'h0022;
    regs[3] = 16'h0033;
    regs[4] = 16'hBEEF;
    regs[5] = 16'h5555;
    regs[6] = 16'h6666;
    regs[7] = 16'h1234;
    rst = 1; cen = 1; start = 0; pull = 0; sel = 0; sp_in = 0;

    repeat (3) @(negedge clk);
    check("rst_ctl", {25'd0, busy, done, bus.bus_req, bus.bus_we,
                      up_hilon, sp_up, 1'b0}, 32'd0);
    check("rst_upen", 32'(up_en), 32'd0);
    check("rst_addr", 32'(bus.bus_addr), 32'd0);
    check("rst_dout", 32'(bus.bus_dout), 32'd0);
    check("rst_updata", 32'(up_data), 32'd0);
    check("rst_spout", 32'(sp_out), 32'd0);
    rst = 0;

    // spurious ack while idle
    force_ack = 1;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("idle_ack", {29'd0, busy, bus.bus_req, |up_en}, 32'd0);
    end
    force_ack = 0;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      model(tbl[r].p, tbl[r].s, tbl[r].sp, tbl[r].w, mspo, mcyc);
      run_op(tbl[r].p, tbl[r].s, tbl[r].sp, tbl[r].w, tbl[r].noisy,
             cyc, spo);
      check($sformatf("vec%0d_cyc", r), 32'(cyc), 32'(tbl[r].cyc));
      check($sformatf("vec%0d_spo", r), 32'(spo), 32'(tbl[r].spo));
      cmp_logs($sformatf("vec%0d", r));
      if (r == 0) begin
        check("mem0FFF", 32'(mem[16'h0FFF]), 32'h34);
        check("mem0FFE", 32'(mem[16'h0FFE]), 32'h12);
        check("mem0FFD", 32'(mem[16'h0FFD]), 32'h56);
      end
      if (r == 1) begin
        uchk(0, 8'h01, 1'b0, 8'h56);
        uchk(1, 8'h80, 1'b1, 8'h12);
        uchk(2, 8'h80, 1'b0, 8'h34);
      end
      if (r == 3) begin
        check("x_lo_at_0000", 32'(mem[16'h0000]), 32'hEF);
        check("x_hi_at_FFFF", 32'(mem[16'hFFFF]), 32'hBE);
      end
    end

    // reset during the second byte of a 16-bit push
    blog.delete();
    ulog.delete();
    waits = 3;
    @(negedge clk);
    pull = 0; sel = 8'h80; sp_in = 16'h3000; start = 1;
    @(negedge clk);
    start = 0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (blog.size() == 1) begin got = 1; break; end
    end
    check("rst_first_byte", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_in_byte2", 32'(bus.bus_req), 32'd1);
    #2 rst = 1;
    #1;
    check("rst_async_req", 32'(bus.bus_req), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 0;
    got = 0;
    repeat (6) begin
      @(negedge clk);
      #2;
      if (done || sp_up || bus.bus_req || |up_en) got = 1;
    end
    check("rst_quiet", 32'(got), 32'd0);
    check("rst_nbus", 32'(blog.size()), 32'd1);

    model(0, 8'h80, 16'h3000, 0, mspo, mcyc);
    run_op(0, 8'h80, 16'h3000, 0, 0, cyc, spo);
    check("after_rst_cyc", 32'(cyc), 32'd5);
    check("after_rst_spo", 32'(spo), 32'h2FFE);
    cmp_logs("after_rst");

    // random operations against the model
    for (int n = 0; n < 16; n++) begin
      bit          p;
      logic [7:0]  s;
      logic [15:0] sp0;
      int          w;
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      p   = 1'($urandom);
      s   = 8'($urandom);
      sp0 = 16'($urandom);
      w   = $urandom_range(0, 2);
      model(p, s, sp0, w, mspo, mcyc);
      run_op(p, s, sp0, w, 0, cyc, spo);
      check($sformatf("rnd%0d_cyc", n), 32'(cyc), 32'(mcyc));
      check($sformatf("rnd%0d_spo", n), 32'(spo), 32'(mspo));
      cmp_logs($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
